// File: rtl/tcam.sv
// Snoop-filter TCAM: tracks sharers/unique ownership per cache-line tag with
// lowest-free allocation and round-robin eviction; result flag is registered.
module tcam #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tag,
  input  logic [6:0]       opcode,
  input  logic [6:0]       NID,
  output logic [3:0]       flag
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NID_W = 7;
  localparam logic [6:0]  OP_READ_SHARED = 7'b0000001;
  localparam logic [6:0]  OP_READ_UNIQUE = 7'b0000111;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] unique_q, unique_d;
  logic [WIDTH-1:0] tag_q [DEPTH];
  logic [WIDTH-1:0] tag_d [DEPTH];
  logic [NID_W-1:0] sharers_q [DEPTH];
  logic [NID_W-1:0] sharers_d [DEPTH];
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [3:0]       flag_q, flag_d;

  logic             is_req;
  logic             is_unique_op;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             snoop;

  assign is_unique_op = (opcode == OP_READ_UNIQUE);
  assign is_req       = ((opcode == OP_READ_SHARED) || is_unique_op) && (NID != '0);

  // Parallel tag match plus lowest-index free-slot search
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (tag_q[i] == tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Directory update and result flag for the sampled request
  always_comb begin
    valid_d   = valid_q;
    unique_d  = unique_q;
    tag_d     = tag_q;
    sharers_d = sharers_q;
    victim_d  = victim_q;
    flag_d    = 4'b0000;
    snoop     = 1'b0;
    alloc_idx = free_found ? free_idx : victim_q;
    if (is_req) begin
      if (hit) begin
        if (is_unique_op) begin
          snoop              = |(sharers_q[hit_idx] & ~NID);
          sharers_d[hit_idx] = NID;
          unique_d[hit_idx]  = 1'b1;
        end else begin
          snoop              = unique_q[hit_idx] && (sharers_q[hit_idx] != NID);
          sharers_d[hit_idx] = sharers_q[hit_idx] | NID;
          unique_d[hit_idx]  = 1'b0;
        end
        flag_d = {1'b0, snoop, 1'b0, 1'b1};
      end else begin
        valid_d[alloc_idx]   = 1'b1;
        tag_d[alloc_idx]     = tag;
        sharers_d[alloc_idx] = NID;
        unique_d[alloc_idx]  = is_unique_op;
        if (free_found) begin
          flag_d = 4'b0010;
        end else begin
          flag_d   = 4'b1010;
          victim_d = victim_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      unique_q <= '0;
      victim_q <= '0;
      flag_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i]     <= '0;
        sharers_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      unique_q  <= unique_d;
      victim_q  <= victim_d;
      flag_q    <= flag_d;
      tag_q     <= tag_d;
      sharers_q <= sharers_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: tb/tb_tcam.sv
// Directed-vector bench for the snoop-filter TCAM; expected flags are
// hand-derived from the sharer/unique rules.
module tb_tcam;

  localparam int unsigned WIDTH = 33;
  localparam int unsigned DEPTH = 8;
  localparam logic [6:0] RS   = 7'b0000001;
  localparam logic [6:0] RU   = 7'b0000111;
  localparam logic [6:0] IDLE = 7'b0000000;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] tag;
  logic [6:0]       opcode;
  logic [6:0]       NID;
  logic [3:0]       flag;

  int tests;
  int fails;

  tcam #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .tag    (tag),
    .opcode (opcode),
    .NID    (NID),
    .flag   (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one request, let it be sampled, then settle just past the edge
  task automatic step(input logic [6:0] op, input logic [6:0] nid, input logic [WIDTH-1:0] tg);
    opcode = op;
    NID    = nid;
    tag    = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    opcode = IDLE;
    NID    = '0;
    tag    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    opcode = RS;
    NID    = 7'b0000001;
    tag    = 33'h0ABCDEFF;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL reset_hold: flag=%b expected %b", flag, 4'b0000); end
    @(negedge clk);
    reset = 1'b1;
    step(RS, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL reset_first_edge: flag=%b expected %b", flag, 4'b0010); end
    reset = 1'b0;
    #1;
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL reset_async_clear: flag=%b expected %b", flag, 4'b0000); end
    @(negedge clk);
    reset = 1'b1;
    step(RS, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL reset_discards: flag=%b expected %b", flag, 4'b0010); end
  endtask

  task automatic test_sharing();
    do_reset();
    step(RS, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL rs_alloc: flag=%b expected %b", flag, 4'b0010); end
    step(RS, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL rs_held: flag=%b expected %b", flag, 4'b0001); end
    step(RU, 7'b0000010, 33'h11223344);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL ru_alloc: flag=%b expected %b", flag, 4'b0010); end
    step(RU, 7'b0000010, 33'h11223344);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL ru_held: flag=%b expected %b", flag, 4'b0001); end
    step(RS, 7'b0000100, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL rs_add_sharer: flag=%b expected %b", flag, 4'b0001); end
    step(RS, 7'b0000001, 33'h11223344);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL rs_snoop_unique: flag=%b expected %b", flag, 4'b0101); end
    // Unique bit is now clear, so a repeat must not snoop
    step(RS, 7'b0000001, 33'h11223344);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL rs_unique_cleared: flag=%b expected %b", flag, 4'b0001); end
    step(RU, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL ru_invalidate: flag=%b expected %b", flag, 4'b0101); end
    step(RS, 7'b0000001, 33'h0ABCDEFF);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL ru_sole_owner: flag=%b expected %b", flag, 4'b0001); end
    step(RU, 7'b0000010, 33'h11223344);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL ru_other_sharers: flag=%b expected %b", flag, 4'b0101); end
  endtask

  task automatic test_idle();
    do_reset();
    step(IDLE, 7'b0000001, 33'h1_0000_0001);
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL idle_opcode: flag=%b expected %b", flag, 4'b0000); end
    step(RS, 7'b0000000, 33'h1_0000_0001);
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL idle_zero_nid: flag=%b expected %b", flag, 4'b0000); end
    step(7'b0000011, 7'b0000001, 33'h1_0000_0001);
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL idle_bad_opcode: flag=%b expected %b", flag, 4'b0000); end
    step(RS, 7'b0000001, 33'h1_0000_0001);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL idle_no_alloc: flag=%b expected %b", flag, 4'b0010); end
  endtask

  task automatic test_evict();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(RS, 7'b0000001, WIDTH'(33'h100 + 33'(i)));
      tests++;
      if (flag !== 4'b0010) begin fails++; $display("FAIL fill_%0d: flag=%b expected %b", i, flag, 4'b0010); end
    end
    step(RS, 7'b0000001, 33'h200);
    tests++;
    if (flag !== 4'b1010) begin fails++; $display("FAIL evict_entry0: flag=%b expected %b", flag, 4'b1010); end
    step(RS, 7'b0000001, 33'h201);
    tests++;
    if (flag !== 4'b1010) begin fails++; $display("FAIL evict_entry1: flag=%b expected %b", flag, 4'b1010); end
    // A hit must not advance the victim pointer (still at entry 2)
    step(RS, 7'b0000001, 33'h102);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL hit_survivor: flag=%b expected %b", flag, 4'b0001); end
    step(RS, 7'b0000001, 33'h100);
    tests++;
    if (flag !== 4'b1010) begin fails++; $display("FAIL evicted_tag_misses: flag=%b expected %b", flag, 4'b1010); end
    step(RS, 7'b0000001, 33'h102);
    tests++;
    if (flag !== 4'b1010) begin fails++; $display("FAIL entry2_was_victim: flag=%b expected %b", flag, 4'b1010); end
    exp = 4'b0001;
    step(RS, 7'b0000001, 33'h200);
    tests++;
    if (flag !== exp) begin fails++; $display("FAIL new_tag_resident: flag=%b expected %b", flag, exp); end
    step(RU, 7'b0000011, 33'h104);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL mask_ru_no_snoop: flag=%b expected %b", flag, 4'b0001); end
    step(RS, 7'b0000001, 33'h104);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL mask_rs_snoop: flag=%b expected %b", flag, 4'b0101); end
    step(IDLE, 7'b0000000, 33'h0);
    tests++;
    if (flag !== 4'b0000) begin fails++; $display("FAIL evict_then_idle: flag=%b expected %b", flag, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(RS, 7'b0000001, 33'h1_AAAA_0000);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL b2b_alloc_a: flag=%b expected %b", flag, 4'b0010); end
    step(RU, 7'b0000010, 33'h1_BBBB_0000);
    tests++;
    if (flag !== 4'b0010) begin fails++; $display("FAIL b2b_alloc_b: flag=%b expected %b", flag, 4'b0010); end
    step(RS, 7'b0000010, 33'h1_AAAA_0000);
    tests++;
    if (flag !== 4'b0001) begin fails++; $display("FAIL b2b_hit_a: flag=%b expected %b", flag, 4'b0001); end
    step(RU, 7'b0000100, 33'h1_BBBB_0000);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL b2b_steal_b: flag=%b expected %b", flag, 4'b0101); end
    step(RU, 7'b0000100, 33'h1_AAAA_0000);
    tests++;
    if (flag !== 4'b0101) begin fails++; $display("FAIL b2b_steal_a: flag=%b expected %b", flag, 4'b0101); end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    opcode = IDLE;
    NID    = '0;
    tag    = '0;
    test_reset();
    test_sharing();
    test_idle();
    test_evict();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
